// File: rtl/systolic_array_param.sv
`default_nettype none
// ============================================================================
// Module  : systolic_array_param
// Brief   : N x N output-stationary systolic array computing C = A x B.
// Revision: 1.0 - initial release
// ============================================================================
module systolic_array_param #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int AW     = 2*DW+2,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  output logic              busy,
  output logic              done,
  output logic [N*N*AW-1:0] res
);

  localparam int         c_cw       = $clog2(2*N);
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_feed  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [c_cw-1:0] r_beat;
  logic [c_cw-1:0] r_drain;
  logic            w_accept;
  logic            w_clear;
  logic            w_run;

  logic [DW-1:0]   w_a_west  [N];
  logic [DW-1:0]   w_b_north [N];
  logic [DW-1:0]   w_a_pe    [N][N];
  logic [DW-1:0]   w_b_pe    [N][N];
  logic [AW-1:0]   w_acc     [N*N];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (start) w_next = c_st_feed;
      c_st_feed:  if (w_accept && (r_beat == c_cw'(N-1))) w_next = c_st_drain;
      c_st_drain: if (r_drain == c_cw'(2*N-2)) w_next = c_st_drain + 2'd1;
      c_st_done:  if (start) w_next = c_st_feed;
      default:    w_next = c_st_idle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      c_st_feed: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      c_st_drain: busy = 1'b1;
      c_st_done:  done = 1'b1;
      default: ;
    endcase
  end

  assign w_run    = busy;
  assign w_accept = in_valid & in_ready;
  assign w_clear  = start & ((r_state == c_st_idle) | (r_state == c_st_done));

  // The drain counter spans exactly the cycles needed for the last operand to
  // reach PE(N-1,N-1), so its final accumulate lands on the DRAIN->DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat  <= '0;
      r_drain <= '0;
    end else begin
      if (w_clear) begin
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + c_cw'(1);
      end
      if (r_state == c_st_drain) begin
        r_drain <= r_drain + c_cw'(1);
      end else begin
        r_drain <= '0;
      end
    end
  end

  // ------------------------------------------------- input stage and skew
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] r_a_in;
    logic [DW-1:0] r_b_in;

    always_ff @(posedge clk) begin
      if (rst || !w_run) begin
        r_a_in <= '0;
        r_b_in <= '0;
      end else begin
        r_a_in <= w_accept ? a_col[i*DW +: DW] : '0;
        r_b_in <= w_accept ? b_row[i*DW +: DW] : '0;
      end
    end

    if (i == 0) begin : g_no_skew
      assign w_a_west[i]  = r_a_in;
      assign w_b_north[i] = r_b_in;
    end else begin : g_skew
      logic [DW-1:0] r_a_sk [i];
      logic [DW-1:0] r_b_sk [i];

      always_ff @(posedge clk) begin
        if (rst || !w_run) begin
          for (int d = 0; d < i; d++) begin
            r_a_sk[d] <= '0;
            r_b_sk[d] <= '0;
          end
        end else begin
          r_a_sk[0] <= r_a_in;
          r_b_sk[0] <= r_b_in;
          for (int d = 1; d < i; d++) begin
            r_a_sk[d] <= r_a_sk[d-1];
            r_b_sk[d] <= r_b_sk[d-1];
          end
        end
      end

      assign w_a_west[i]  = r_a_sk[i-1];
      assign w_b_north[i] = r_b_sk[i-1];
    end
  end

  // ------------------------------------------------------- PE grid
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [2*DW-1:0] w_ax;
      logic [2*DW-1:0] w_bx;
      logic [2*DW-1:0] w_prod;
      logic [AW-1:0]   w_ext;
      logic [AW-1:0]   r_acc;

      if (j == 0) begin : g_west_edge
        assign w_a_pe[i][0] = w_a_west[i];
      end
      if (i == 0) begin : g_north_edge
        assign w_b_pe[0][j] = w_b_north[j];
      end

      // Operands are extended to 2*DW before multiplying so the low 2*DW
      // bits of the product are exact for either signedness.
      if (SIGNED != 0) begin : g_signed
        assign w_ax   = {{DW{w_a_pe[i][j][DW-1]}}, w_a_pe[i][j]};
        assign w_bx   = {{DW{w_b_pe[i][j][DW-1]}}, w_b_pe[i][j]};
        assign w_prod = w_ax * w_bx;
        assign w_ext  = AW'($signed(w_prod));
      end else begin : g_unsigned
        assign w_ax   = {{DW{1'b0}}, w_a_pe[i][j]};
        assign w_bx   = {{DW{1'b0}}, w_b_pe[i][j]};
        assign w_prod = w_ax * w_bx;
        assign w_ext  = AW'(w_prod);
      end

      always_ff @(posedge clk) begin
        if (rst || w_clear) begin
          r_acc <= '0;
        end else if (w_run) begin
          r_acc <= r_acc + w_ext;
        end
      end

      if (j < N-1) begin : g_east
        logic [DW-1:0] r_a_e;
        always_ff @(posedge clk) begin
          if (rst || !w_run) begin
            r_a_e <= '0;
          end else begin
            r_a_e <= w_a_pe[i][j];
          end
        end
        assign w_a_pe[i][j+1] = r_a_e;
      end

      if (i < N-1) begin : g_south
        logic [DW-1:0] r_b_s;
        always_ff @(posedge clk) begin
          if (rst || !w_run) begin
            r_b_s <= '0;
          end else begin
            r_b_s <= w_b_pe[i][j];
          end
        end
        assign w_b_pe[i+1][j] = r_b_s;
      end

      assign w_acc[i*N+j] = r_acc;
    end
  end

  always_comb begin
    res = '0;
    for (int k = 0; k < N*N; k++) begin
      res[k*AW +: AW] = w_acc[k];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_array_param
// Brief   : Directed bench for systolic_array_param, unsigned and signed copies.
// Revision: 1.0 - initial release
// ============================================================================
module tb_systolic_array_param;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [N*DW-1:0]   a_col;
  logic [N*DW-1:0]   b_row;
  logic              in_ready_u, busy_u, done_u;
  logic              in_ready_s, busy_s, done_s;
  logic [N*N*AW-1:0] res_u;
  logic [N*N*AW-1:0] res_s;

  int checks = 0;
  int errors = 0;
  int ma [N][N];
  int mb [N][N];

  always #5 clk = ~clk;

  systolic_array_param #(.N(N), .DW(DW), .AW(AW), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_u), .a_col(a_col), .b_row(b_row),
    .busy(busy_u), .done(done_u), .res(res_u)
  );

  systolic_array_param #(.N(N), .DW(DW), .AW(AW), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_s), .a_col(a_col), .b_row(b_row),
    .busy(busy_s), .done(done_s), .res(res_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] model(input int i, input int j, input bit sgn);
    int s;
    int av;
    int bv;
    s = 0;
    for (int k = 0; k < N; k++) begin
      av = ma[i][k] & 255;
      bv = mb[k][j] & 255;
      if (sgn && av > 127) av -= 256;
      if (sgn && bv > 127) bv -= 256;
      s += av * bv;
    end
    return AW'(s);
  endfunction

  task automatic check_res(input string tag);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check($sformatf("%s_u_c%0d%0d", tag, i, j), 32'(res_u[(i*N+j)*AW +: AW]), 32'(model(i, j, 1'b0)));
        check($sformatf("%s_s_c%0d%0d", tag, i, j), 32'(res_s[(i*N+j)*AW +: AW]), 32'(model(i, j, 1'b1)));
      end
    end
  endtask

  // mode 0: plain, 1: start pulses in FEED and DRAIN, 2: start held high,
  // 3: reset two cycles into DRAIN
  task automatic run(input string tag, input int bub, input int mode, input int exp_cyc);
    int edges;
    @(posedge clk); #1;
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    if (mode != 2) start = 1'b0;
    edges = 0;
    check({tag, "_busy_feed"}, busy_u, 1'b1);
    check({tag, "_ready_feed"}, in_ready_u, 1'b1);
    for (int k = 0; k < N; k++) begin
      if (k == 2) begin
        repeat (bub) begin
          @(posedge clk); edges++; #1;
        end
      end
      in_valid = 1'b1;
      for (int r = 0; r < N; r++) begin
        a_col[r*DW +: DW] = 8'(ma[r][k]);
        b_row[r*DW +: DW] = 8'(mb[k][r]);
      end
      if (mode == 1 && k == 1) start = 1'b1;
      @(posedge clk); edges++; #1;
      in_valid = 1'b0;
      if (mode == 1) start = 1'b0;
    end
    while (!done_u && edges < 60) begin
      start = (mode == 2) || (mode == 1 && edges == N+2);
      if (mode == 3 && edges == N+2) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, "_rst_busy"}, busy_u, 1'b0);
        check({tag, "_rst_done"}, done_u, 1'b0);
        check({tag, "_rst_ready"}, in_ready_u, 1'b0);
        check({tag, "_rst_res_u"}, (res_u == '0), 1'b1);
        check({tag, "_rst_res_s"}, (res_s == '0), 1'b1);
        @(posedge clk); #1;
        check({tag, "_rst_idle"}, {busy_u, done_u}, 2'b00);
        return;
      end
      @(posedge clk); edges++; #1;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, edges + 1, exp_cyc);
    check({tag, "_busy_at_done"}, busy_u, 1'b0);
    check({tag, "_done_s"}, done_s, 1'b1);
    check_res(tag);
  endtask

  task automatic load_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 4*i + j + 1;
      end
  endtask

  task automatic load_fill(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
      end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    a_col    = '0;
    b_row    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy_u, 1'b0);
    check("reset_done", done_u, 1'b0);
    check("reset_ready", in_ready_u, 1'b0);
    check("reset_res", (res_u == '0) && (res_s == '0), 1'b1);
    rst = 1'b0;

    load_identity();
    run("ident", 0, 0, 12);
    repeat (2) @(posedge clk);
    #1;
    check("ident_hold_done", done_u, 1'b1);
    check("ident_hold_c33", 32'(res_u[15*AW +: AW]), 32'd16);

    load_fill(255, 255);
    run("max", 0, 0, 12);
    check("max_literal", 32'(res_u[5*AW +: AW]), 32'd260100);

    load_fill(128, 128);
    run("neg128", 0, 0, 12);
    check("neg128_literal", 32'(res_s[0 +: AW]), 32'd65536);

    load_fill(255, 1);
    run("neg1", 0, 0, 12);
    check("neg1_literal", 32'(res_s[7*AW +: AW]), 32'h3FFFC);

    load_identity();
    run("bubble", 3, 0, 15);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i*16 + j*3 + 1;
        mb[i][j] = (i*37 + j*11 + 100) & 255;
      end
    run("ctl", 0, 1, 12);
    run("rstmid", 0, 3, 12);
    load_fill(200, 3);
    run("rerun", 0, 0, 12);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i + 2*j + 250) & 255;
        mb[i][j] = (3*i + j) & 255;
      end
    run("b2b_a", 0, 2, 12);
    load_identity();
    run("b2b_b", 0, 0, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_array_param.md
SYSTOLIC_ARRAY_PARAM -- requirements
Module: systolic_array_param

Interface
REQ-001 SHALL have parameter N, default 4: array dimension, N x N processing elements; legal range 2..16.
REQ-002 SHALL have parameter DW, default 8: operand width in bits.
REQ-003 SHALL have parameter AW, default 2*DW+2: accumulator and result width in bits; must satisfy AW >= 2*DW.
REQ-004 SHALL have parameter SIGNED, default 0: 0 treats operands as unsigned, 1 as two's complement.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: request a new N x N matrix product.
REQ-008 SHALL have port in_valid, input, 1 bit: an operand beat is present on a_col and b_row.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts an operand beat this cycle.
REQ-010 SHALL have port a_col, input, N*DW bits: column k of A; row i at bits [i*DW +: DW].
REQ-011 SHALL have port b_row, input, N*DW bits: row k of B; column j at bits [j*DW +: DW].
REQ-012 SHALL have port busy, output, 1 bit: a product is in progress (state FEED or DRAIN).
REQ-013 SHALL have port done, output, 1 bit: result is valid and held.
REQ-014 SHALL have port res, output, N*N*AW bits: C(i,j) at bits [(i*N+j)*AW +: AW].

Function
REQ-015 SHALL implement FSM IDLE, FEED, DRAIN, DONE.
- IDLE->FEED, and DONE->FEED, on start=1.
- FEED->DRAIN on acceptance of beat N-1.
- DRAIN->DONE after exactly 2N-1 DRAIN cycles.
REQ-016 SHALL clear every accumulator on the edge that accepts start, and reset the beat counter to 0.
REQ-017 SHALL ignore start in FEED and DRAIN, with no effect on state, counters or accumulators.
REQ-018 SHALL drive in_ready=1 only in FEED; a beat SHALL be accepted on any edge where in_valid=1 and in_ready=1.
REQ-019 SHALL skew operands internally: A row i delayed i cycles; B column j delayed j cycles.
REQ-020 PE(i,j) SHALL pass its A operand east and its B operand south through one register each, and accumulate the product of its two inputs every cycle.
REQ-021 SHALL advance the skew and PE pipeline every cycle in FEED and DRAIN; any FEED cycle without a beat SHALL inject zero operands, so bubbles contribute 0.
REQ-022 SHALL keep the skew and PE pipeline idle with zero operands in IDLE and DONE; accumulators SHALL hold in those states.
REQ-023 SHALL form the product at 2*DW bits, signed or unsigned per SIGNED, sign- or zero-extend it to AW, and add modulo 2^AW (wrap, no saturation).
REQ-024 SHALL make the final accumulate of PE(N-1,N-1) coincide with the DRAIN->DONE edge, so res is complete on the first cycle done=1.
REQ-025 SHALL give, with no bubbles, done=1 exactly 3N cycles after the start-acceptance edge (12 for N=4).
REQ-026 SHALL drive res directly from the accumulators, holding in DONE until the next start is accepted; res is don't-care while busy=1.
REQ-027 SHALL assert done=1 only in DONE, and busy=1 only in FEED or DRAIN; done and busy SHALL never both be 1.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force state IDLE, all accumulators, skew and pipeline registers, and beat and drain counters to 0.
REQ-029 SHALL hold busy=0, done=0, in_ready=0 and res=0 after reset.
REQ-030 SHALL give rst priority over start and in_valid; a product in progress is discarded and no beat is accepted on that edge.

Verification
REQ-031 Identity: N=4, SIGNED=0, A=I, B(i,j)=4i+j+1, beats back-to-back -> done at cycle 12; C(i,j)=4i+j+1.
REQ-032 Unsigned max: N=4, all operands 255 -> every C(i,j)=260100; AW=18, no wrap.
REQ-033 Signed: SIGNED=1, all A=-128, all B=-128 -> every C(i,j)=65536; then A=-1, B=1 -> every C(i,j)=-4 (0x3FFFC).
REQ-034 Bubbles: identity test with in_valid low for 3 cycles between beats 1 and 2 -> results unchanged; done at cycle 15.
REQ-035 Control: start pulsed during FEED and DRAIN -> ignored. rst asserted mid-DRAIN -> IDLE next cycle, res=0; a new start then gives a correct result.
REQ-036 Back-to-back: start held high in DONE -> accumulators cleared, FEED entered; the second product is unaffected by the first.
